serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor computing d = a - b, LSB first, one bit per clock, with a start/busy/done handshake. It is the inverse-direction companion of the registered four-bit adder: it recovers an operand from a sum, or forms a difference. It trades adder area for WIDTH cycles of latency. Its result layout mirrors the adder's (WIDTH+1)-bit output, with the MSB carrying the borrow.

---
 rtl/serial_subtractor_pkg.sv | 24 ++
 rtl/serial_subtractor_full_subtractor.sv | 21 ++
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// +----------------------------------------------------------------------+
// | serial_subtractor_pkg                                                |
// | Shared types and constants for the bit-serial subtractor.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package serial_subtractor_pkg;

  localparam int c_default_width = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The borrow sits directly above the difference bits in d.
  function automatic int borrow_bit(input int width);
    return width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
// +----------------------------------------------------------------------+
// | full_subtractor                                                      |
// | One-bit combinational subtract stage: x - y - bin.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// +----------------------------------------------------------------------+
// | serial_subtractor                                                    |
// | LSB-first bit-serial d = a - b with start/busy/done handshake.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   d
);

  localparam int c_borrow_pos = borrow_bit(WIDTH);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic               w_last;

  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_diff;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_borrow;
  logic               r_done;
  logic [WIDTH:0]     r_d;

  logic               w_bit;
  logic               w_borrow_next;
  logic [WIDTH-1:0]   w_diff_next;

  full_subtractor u_fs (
    .x    (r_a_sh[0]),
    .y    (r_b_sh[0]),
    .bin  (r_borrow),
    .diff (w_bit),
    .bout (w_borrow_next)
  );

  assign w_diff_next = {w_bit, r_diff[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_last       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_done   <= 1'b0;
      r_d      <= '0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a_sh   <= a;
        r_b_sh   <= b;
        r_borrow <= 1'b0;
        r_cnt    <= '0;
      end else if (r_state == RUN) begin
        r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
        r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
        r_diff   <= w_diff_next;
        r_borrow <= w_borrow_next;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
      // The final bit never lands in r_diff first; d takes it straight from the stage.
      if (w_last) begin
        r_d[c_borrow_pos]  <= w_borrow_next;
        r_d[WIDTH-1:0]     <= w_diff_next;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign d    = r_d;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// +----------------------------------------------------------------------+
// | tb_serial_subtractor                                                 |
// | Directed self-checking bench for serial_subtractor (WIDTH=4).        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W:0]   d;

  int checks;
  int errors;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (d !== 5'b00000) begin errors++; $display("FAIL reset_d got %b want 00000", d); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W:0] exp);
    start = 1'b1; a = ta; b = tb;
    step();
    start = 1'b0; a = ~ta; b = ~tb;  // operands must not be re-read after acceptance
    for (int k = 1; k <= W; k++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL op_busy a=%b b=%b cyc=%0d got %b want 1", ta, tb, k, busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL op_early_done a=%b b=%b cyc=%0d got %b want 0", ta, tb, k, done); end
      step();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL op_done a=%b b=%b got %b want 1", ta, tb, done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL op_busy_end a=%b b=%b got %b want 0", ta, tb, busy); end
    checks++; if (d !== exp) begin errors++; $display("FAIL op_d a=%b b=%b got %b want %b", ta, tb, d, exp); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL op_done_pulse a=%b b=%b got %b want 0", ta, tb, done); end
    checks++; if (d !== exp) begin errors++; $display("FAIL op_d_hold a=%b b=%b got %b want %b", ta, tb, d, exp); end
  endtask

  task automatic test_ignore_busy();
    int pulses;
    logic [W:0] seen;
    pulses = 0; seen = '0;
    start = 1'b1; a = 4'b1100; b = 4'b0011;
    step();
    start = 1'b0;
    step();
    start = 1'b1; a = 4'b0000; b = 4'b0001;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done === 1'b1) begin pulses++; seen = d; end
      step();
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    checks++; if (seen !== 5'b01001) begin errors++; $display("FAIL ignore_d got %b want 01001", seen); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    start = 1'b1; a = 4'b1010; b = 4'b1100;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
    checks++; if (d !== 5'b00000) begin errors++; $display("FAIL midrst_d got %b want 00000", d); end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (done === 1'b1) pulses++;
      step();
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_late_done got %0d want 0", pulses); end
    test_op(4'b0010, 4'b1000, 5'b11010);
  endtask

  task automatic test_back_to_back();
    int  gap;
    bit  found;
    start = 1'b1; a = 4'b1000; b = 4'b0001;
    step();
    a = 4'b0011; b = 4'b0011;
    found = 1'b0;
    for (int k = 0; k < 2 * W && !found; k++) begin
      if (done === 1'b1) found = 1'b1; else step();
    end
    checks++; if (!found) begin errors++; $display("FAIL b2b_first_timeout got 0 want 1"); end
    checks++; if (d !== 5'b00111) begin errors++; $display("FAIL b2b_first_d got %b want 00111", d); end
    found = 1'b0; gap = 0;
    step(); gap++;
    for (int k = 0; k < 2 * W && !found; k++) begin
      if (done === 1'b1) found = 1'b1; else begin step(); gap++; end
    end
    start = 1'b0;
    checks++; if (!found) begin errors++; $display("FAIL b2b_second_timeout got 0 want 1"); end
    checks++; if (d !== 5'b00000) begin errors++; $display("FAIL b2b_second_d got %b want 00000", d); end
    checks++; if (gap < W || gap > W + 1) begin errors++; $display("FAIL b2b_gap got %0d want %0d..%0d", gap, W, W + 1); end
    for (int k = 0; k < 2 * W; k++) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_op(4'b1010, 4'b0101, 5'b00101);
    test_op(4'b0101, 4'b1010, 5'b11011);
    test_op(4'b0000, 4'b0000, 5'b00000);
    test_op(4'b1111, 4'b0001, 5'b01110);
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
